// File: rtl/wb_ssram_if_pkg.sv
// ============================================================================
// wb_ssram_if_pkg : shared types and defaults for the SSRAM write buffer
// rev 1.0
// ============================================================================
`default_nettype none

package wb_ssram_if_pkg;

  localparam int WBUF_DEPTH_DEF = 4;

  typedef enum logic [3:0] {
    M_IDLE  = 4'b0001,
    M_WRITE = 4'b0010,
    M_READ  = 4'b0100,
    M_GAP   = 4'b1000
  } m_state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wbuf_entry_t;

  localparam int WBUF_DW = $bits(wbuf_entry_t);

endpackage

`default_nettype wire

// File: rtl/wb_ssram_wbuf_fifo.sv
// ============================================================================
// wb_ssram_wbuf_fifo : synchronous FIFO holding posted write entries
// rev 1.0
// ============================================================================
`default_nettype none

module wb_ssram_wbuf_fifo
  import wb_ssram_if_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEF,
  parameter int WIDTH = WBUF_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_level == LW'(DEPTH));
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign rd_data = r_mem[r_rptr];

  // Protect the pointers from a caller that pushes full or pops empty.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/wb_ssram_wbuf.sv
// ============================================================================
// wb_ssram_wbuf : Wishbone posted-write buffer in front of an SSRAM port
// rev 1.0
// ============================================================================
`default_nettype none

module wb_ssram_wbuf
  import wb_ssram_if_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            s_adr,
  input  logic [31:0]            s_din,
  input  logic [3:0]             s_sel,
  input  logic                   s_we,
  input  logic                   s_cyc,
  input  logic                   s_stb,
  output logic [31:0]            s_dout,
  output logic                   s_ack,
  output logic                   s_err,
  output logic                   s_rty,
  output logic [31:0]            m_adr,
  output logic [31:0]            m_dout,
  output logic [3:0]             m_sel,
  output logic                   m_we,
  output logic                   m_cyc,
  output logic                   m_stb,
  input  logic [31:0]            m_din,
  input  logic                   m_ack,
  input  logic                   m_err,
  input  logic                   m_rty,
  output logic [$clog2(DEPTH):0] wbuf_level,
  output logic                   wbuf_err
);

  m_state_t    r_state;
  wbuf_entry_t w_wr_entry;
  wbuf_entry_t w_head;
  logic        w_req;
  logic        w_push;
  logic        w_pop;
  logic        w_rd_pend;
  logic        w_full;
  logic        w_empty;
  logic        w_unused;

  // A request whose response is on the bus this cycle must not be seen again.
  assign w_req      = s_cyc & s_stb & ~s_ack & ~s_err;
  assign w_push     = w_req & s_we & ~w_full;
  assign w_rd_pend  = w_req & ~s_we;
  assign w_pop      = (r_state == M_WRITE) & (m_ack | m_err);
  assign w_wr_entry = '{adr: s_adr, dat: s_din, sel: s_sel};

  assign s_rty    = 1'b0;
  assign w_unused = m_rty;

  wb_ssram_wbuf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WBUF_DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wr_data (w_wr_entry),
    .pop     (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (wbuf_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= M_IDLE;
      s_ack    <= 1'b0;
      s_err    <= 1'b0;
      s_dout   <= '0;
      m_adr    <= '0;
      m_dout   <= '0;
      m_sel    <= '0;
      m_we     <= 1'b0;
      m_cyc    <= 1'b0;
      m_stb    <= 1'b0;
      wbuf_err <= 1'b0;
    end else begin
      s_ack  <= w_push;
      s_err  <= 1'b0;
      s_dout <= '0;
      case (r_state)
        M_IDLE: begin
          if (!w_empty) begin
            m_cyc   <= 1'b1;
            m_stb   <= 1'b1;
            m_we    <= 1'b1;
            m_adr   <= w_head.adr;
            m_dout  <= w_head.dat;
            m_sel   <= w_head.sel;
            r_state <= M_WRITE;
          end else if (w_rd_pend) begin
            m_cyc   <= 1'b1;
            m_stb   <= 1'b1;
            m_we    <= 1'b0;
            m_adr   <= s_adr;
            m_dout  <= '0;
            m_sel   <= s_sel;
            r_state <= M_READ;
          end
        end
        M_WRITE, M_READ: begin
          if (m_ack || m_err) begin
            m_cyc  <= 1'b0;
            m_stb  <= 1'b0;
            m_we   <= 1'b0;
            m_adr  <= '0;
            m_dout <= '0;
            m_sel  <= '0;
            // A failed posted write has no requester left to tell; flag it sticky.
            if (r_state == M_WRITE) begin
              if (m_err) wbuf_err <= 1'b1;
            end else if (m_err) begin
              s_err <= 1'b1;
            end else begin
              s_ack  <= 1'b1;
              s_dout <= m_din;
            end
            r_state <= M_GAP;
          end
        end
        M_GAP:   r_state <= M_IDLE;
        default: r_state <= M_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/wb_ssram_wbuf.md
WB_SSRAM_WBUF -- requirements
Module: wb_ssram_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, 4, write-buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have slave ports s_adr in 32, s_din in 32, s_sel in 4, s_we in 1, s_cyc in 1, s_stb in 1; upstream Wishbone request.
REQ-005 SHALL have slave ports s_dout out 32, s_ack out 1, s_err out 1, s_rty out 1; upstream response.
REQ-006 SHALL have master ports m_adr out 32, m_dout out 32, m_sel out 4, m_we out 1, m_cyc out 1, m_stb out 1; request to the SSRAM Wishbone interface.
REQ-007 SHALL have master ports m_din in 32, m_ack in 1, m_err in 1, m_rty in 1; response from the SSRAM interface.
REQ-008 SHALL have status ports wbuf_level out clog2(DEPTH)+1 (occupied entries) and wbuf_err out 1 (sticky posted-write error).

Function
REQ-009 SHALL sample a slave request only when s_cyc&s_stb=1 and s_ack=0 and s_err=0, so that one request is never accepted twice.
REQ-010 SHALL accept a slave write when buffer not full: push {s_adr,s_din,s_sel}, assert s_ack for exactly one cycle on the next clock.
REQ-011 SHALL stall a slave write (no s_ack) while buffer full; accept in the cycle after an entry is popped.
REQ-012 SHALL stall a slave read until buffer empty and master FSM in M_IDLE (read-after-write ordering); no forwarding from buffer.
REQ-013 SHALL return read data: s_dout=m_din and s_ack=1 for one cycle, on the clock after m_ack; s_dout=0 in all other cycles.
REQ-014 SHALL on m_err during a read pulse s_err for one cycle instead of s_ack.
REQ-015 SHALL on m_err during a posted write pop the entry, set wbuf_err, and continue draining.
REQ-016 SHALL drive s_rty=0 permanently; m_rty ignored.
REQ-017 SHALL pass s_sel and data unmodified (no byte swap; endianness handled downstream).
REQ-018 SHALL implement master FSM states M_IDLE, M_WRITE, M_READ, M_GAP, one-hot.
REQ-019 SHALL M_IDLE->M_WRITE when buffer non-empty (writes take priority); M_IDLE->M_READ when pending read and buffer empty.
REQ-020 SHALL in M_WRITE/M_READ hold m_cyc=m_stb=1 with stable m_adr/m_dout/m_sel/m_we until m_ack or m_err.
REQ-021 SHALL on m_ack/m_err go to M_GAP (m_cyc=m_stb=0 one cycle), then M_IDLE; pop happens on the m_ack/m_err edge of M_WRITE.
REQ-022 SHALL drive m_adr, m_dout, m_sel, m_we, m_dout from registers; 0 when m_stb=0.
REQ-023 SHALL keep wbuf_level unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-024 SHALL drop a stalled slave request without side effect if s_cyc or s_stb deasserts before acceptance.

Reset
REQ-025 SHALL on rst: s_ack, s_err, s_rty, m_cyc, m_stb, m_we = 0; s_dout, m_adr, m_dout = 0; m_sel = 0; wbuf_level=0; wbuf_err=0; FSM=M_IDLE.
REQ-026 SHALL on rst mid-operation discard all buffered writes and any pending read; no further master cycle until a new request.
REQ-027 SHALL clear wbuf_err only by rst.

Structure
REQ-028 SHALL place FSM state encodings and DEPTH default in shared package wb_ssram_if_pkg.
REQ-029 SHALL implement the buffer as sub-module wb_ssram_wbuf_fifo: synchronous 68-bit-wide FIFO, push/pop/full/empty/level, same clk/rst.

Verification
REQ-030 Single write adr=0x100, din=0xDEADBEEF, sel=0xF -> s_ack 1 cycle after request; m_stb with same values within 2 cycles; level 1->0 after m_ack.
REQ-031 DEPTH=4, five back-to-back writes, m_ack held 0 -> four acked, fifth stalled; release m_ack -> fifth acked after first pop; order preserved on master.
REQ-032 Write adr=0x200 data=0x12345678 then read adr=0x200 -> read issued on master only after write m_ack and M_GAP; s_dout=0x12345678 with s_ack.
REQ-033 Posted write with m_err=1 -> entry popped, wbuf_err=1, next entry drained; read with m_err -> s_err pulse, s_ack stays 0.
REQ-034 rst asserted with 3 entries buffered and m_stb=1 -> m_stb=0, level=0 immediately; no master cycle after rst release without new request.
REQ-035 Simultaneous push and pop at level 2 with write pointer at DEPTH-1 -> level stays 2, pointer wraps to 0, data intact.
